// File: rtl/mem_pkg.sv
// Shared types and widths for the handshaked data-memory responder.
package mem_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned WAIT_W = 4;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

   // Word-index width for a RAM of the given depth (never narrower than one bit).
   function automatic int unsigned idx_width(int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write port, combinational read port at the same index.
module dmem_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned IDX_W = idx_width(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request and response channels, programmable wait states.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [WORD_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [WORD_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int unsigned IDX_W = idx_width(DEPTH);

   resp_state_t       state_q;
   logic [WAIT_W-1:0] cnt_q;
   logic              we_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] rd_data;
   logic              acc_err;
   logic              access;
   logic              wr_en;

   // Full 30-bit word index is range-checked so high address bits never alias into the RAM.
   assign acc_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[WORD_W-1:2]} >= WORD_W'(DEPTH));
   assign access  = (state_q == WAIT) && (cnt_q == '0);
   // Reset on the access edge suppresses the write.
   assign wr_en   = reset && access && we_q && !acc_err;

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (wr_en),
      .idx   (addr_q[IDX_W+1:2]),
      .wdata (wdata_q),
      .rdata (rd_data)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  we_q      <= req_we;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  cnt_q     <= WAIT_W'(WAIT_CYCLES);
                  req_ready <= 1'b0;
                  state_q   <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - WAIT_W'(1);
               end else begin
                  resp_rdata <= (we_q || acc_err) ? '0 : rd_data;
                  resp_err   <= acc_err;
                  resp_valid <= 1'b1;
                  state_q    <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_rdata <= '0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: two responders (2 and 0 wait states) with directed load/store vectors.
module tb_dmem_responder;
   import mem_pkg::*;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Index 0: WAIT_CYCLES=2 responder, index 1: WAIT_CYCLES=0 responder.
   logic [1:0]       req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
   logic [1:0][31:0] req_addr, req_wdata, resp_rdata;

   exp_t q0[$];
   exp_t q1[$];
   int   n_vec = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   acc_cyc [2];
   logic [1:0] vld_prev = 2'b00;

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[0]),
      .req_ready  (req_ready[0]),
      .req_we     (req_we[0]),
      .req_addr   (req_addr[0]),
      .req_wdata  (req_wdata[0]),
      .resp_valid (resp_valid[0]),
      .resp_ready (resp_ready[0]),
      .resp_rdata (resp_rdata[0]),
      .resp_err   (resp_err[0])
   );

   dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid[1]),
      .req_ready  (req_ready[1]),
      .req_we     (req_we[1]),
      .req_addr   (req_addr[1]),
      .req_wdata  (req_wdata[1]),
      .resp_valid (resp_valid[1]),
      .resp_ready (resp_ready[1]),
      .resp_rdata (resp_rdata[1]),
      .resp_err   (resp_err[1])
   );

   always @(posedge clk) cyc++;

   function automatic int wc(int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail_timeout(string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: got timeout, expected handshake", name);
   endtask

   // Monitor: response latency on rising resp_valid, scoreboard pop on each response handshake.
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (resp_valid[d] === 1'b1 && vld_prev[d] !== 1'b1)
            chk($sformatf("latency%0d", d), 32'(cyc - acc_cyc[d]), 32'(wc(d) + 1));
         if (resp_valid[d] === 1'b1 && resp_ready[d] === 1'b1) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
               n_vec++;
               n_bad++;
               $display("FAIL unexpected_resp%0d: got response, expected none", d);
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk({e.name, "_rdata"}, resp_rdata[d], e.rdata);
               chk({e.name, "_err"}, {31'b0, resp_err[d]}, {31'b0, e.err});
            end
         end
      end
      vld_prev = resp_valid;
   end

   task automatic issue(int d, bit we, logic [31:0] addr, logic [31:0] wdata, bit expect_resp,
                        logic [31:0] erd, bit eerr, string name);
      exp_t e;
      int   n;
      if (expect_resp) begin
         e = '{rdata: erd, err: eerr, name: name};
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_we[d]    = we;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      n = 0;
      while (req_ready[d] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (req_ready[d] !== 1'b1) begin
         fail_timeout({name, "_accept"});
         req_valid[d] = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      acc_cyc[d]   = cyc;
      req_valid[d] = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q0.size() != 0 || q1.size() != 0 || req_ready !== 2'b11) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) fail_timeout("drain");
   endtask

   task automatic chk_reset_outputs(int d, string tag);
      chk({tag, "_req_ready"}, {31'b0, req_ready[d]}, 32'd1);
      chk({tag, "_resp_valid"}, {31'b0, resp_valid[d]}, 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata[d], 32'd0);
      chk({tag, "_resp_err"}, {31'b0, resp_err[d]}, 32'd0);
   endtask

   initial begin
      int t0;
      int n;
      req_valid  = '0;
      req_we     = '0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 2'b11;
      reset      = 1'b0;
      acc_cyc    = '{0, 0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0, "rst_w2");
      chk_reset_outputs(1, "rst_w0");
      reset = 1'b1;

      // Store then load with two wait states.
      issue(0, 1'b1, 32'h64, 32'd7, 1'b1, 32'd0, 1'b0, "st64");
      issue(0, 1'b0, 32'h64, 32'd0, 1'b1, 32'd7, 1'b0, "ld64");

      // Zero wait states, back to back with resp_ready held high.
      issue(1, 1'b1, 32'h0, 32'h1234_5678, 1'b1, 32'd0, 1'b0, "st0");
      t0 = acc_cyc[1];
      issue(1, 1'b0, 32'h0, 32'd0, 1'b1, 32'h1234_5678, 1'b0, "ld0");
      chk("spacing", 32'(acc_cyc[1] - t0), 32'd3);
      drain();

      // Error cases leave RAM untouched; top word index is still legal.
      issue(0, 1'b1, 32'h62, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, "st_misalign");
      issue(0, 1'b1, 32'h100, 32'hFFFF_FFFF, 1'b1, 32'd0, 1'b1, "st_range");
      issue(0, 1'b0, 32'hFFFF_FF00, 32'd0, 1'b1, 32'd0, 1'b1, "ld_high");
      issue(0, 1'b0, 32'h64, 32'd0, 1'b1, 32'd7, 1'b0, "reld64");
      issue(0, 1'b1, 32'hFC, 32'hA5A5_A5A5, 1'b1, 32'd0, 1'b0, "st_fc");
      issue(0, 1'b0, 32'hFC, 32'd0, 1'b1, 32'hA5A5_A5A5, 1'b0, "ld_fc");
      drain();

      // Backpressure: response must hold while resp_ready is low.
      resp_ready[0] = 1'b0;
      issue(0, 1'b0, 32'h64, 32'd0, 1'b1, 32'd7, 1'b0, "ld_bp");
      n = 0;
      while (resp_valid[0] !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (resp_valid[0] !== 1'b1) fail_timeout("bp_valid");
      for (int i = 0; i < 5; i++) begin
         if (i != 0) @(negedge clk);
         chk("bp_valid", {31'b0, resp_valid[0]}, 32'd1);
         chk("bp_rdata", resp_rdata[0], 32'd7);
         chk("bp_err", {31'b0, resp_err[0]}, 32'd0);
         chk("bp_req_ready", {31'b0, req_ready[0]}, 32'd0);
      end
      @(posedge clk);
      #1 resp_ready[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_ready", {31'b0, req_ready[0]}, 32'd1);
      chk("bp_release_valid", {31'b0, resp_valid[0]}, 32'd0);
      drain();

      // Reset during WAIT discards the pending store.
      issue(0, 1'b1, 32'h8, 32'h11, 1'b1, 32'd0, 1'b0, "st8");
      drain();
      issue(0, 1'b1, 32'h8, 32'hDEAD, 1'b0, 32'd0, 1'b0, "st8_dead");
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_reset_outputs(0, "midrst");
      reset = 1'b1;
      issue(0, 1'b0, 32'h8, 32'd0, 1'b1, 32'h11, 1'b0, "ld8");
      drain();

      chk("leftover", 32'(q0.size() + q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory that answers processor load/store requests over a valid/ready request channel and a valid/ready response channel, with a programmable number of wait states. It is the memory-side end of the data bus: it replaces the zero-latency `dmem` when the core is moved to a handshaked memory interface, and it lets the bench exercise stall behaviour. One request is outstanding at a time; accesses that are misaligned or out of range are answered with an error and no side effects.

## Interface
- `DEPTH`, 64: number of 32-bit words; legal word index 0..DEPTH-1.
- `WAIT_CYCLES`, 2: extra wait states between request acceptance and the memory access; range 0..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of `clk`).
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester accepts the response.
- `resp_rdata`  out  32  load data; 0 for stores and errors.
- `resp_err`  out  1  request was misaligned or out of range.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On an edge with `req_valid`=1, latch `req_we`, `req_addr`, `req_wdata`; load `cnt`=WAIT_CYCLES; go to WAIT. Request inputs are ignored in all other states.
- WAIT: `req_ready`=0 and `resp_valid`=0.
  - If `cnt`!=0 at an edge, decrement `cnt`.
  - If `cnt`==0 at an edge, perform the access, register `resp_rdata`/`resp_err`, and go to RESP.
- Access rules:
  - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
  - err: no write; `resp_rdata`=0; `resp_err`=1.
  - Store without err: RAM[addr[31:2]] <= wdata; `resp_rdata`=0.
  - Load without err: `resp_rdata`=RAM[addr[31:2]].
- RESP: `resp_valid`=1. `resp_rdata` and `resp_err` are held stable until the edge where `resp_ready`=1; that edge moves the FSM to IDLE. There is no direct RESP-to-accept path; `req_ready` rises the cycle after the response handshake.
- RAM contents are not cleared by reset and are undefined at power-up.

## Timing
- Reset (`reset`=0 at an edge) returns the FSM to IDLE. The next cycle, all outputs take their reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0; `cnt`=0.
- Reset during WAIT: a store that has not reached its access edge is discarded, and RAM is unchanged.
- Reset during RESP: the response is dropped.
- Reset during the access edge itself: reset wins and no write occurs.
- Latency: if the request is accepted at edge E0, the access happens at edge E0+WAIT_CYCLES+1, and `resp_valid` is high in the cycle that follows.
- With WAIT_CYCLES=0, `resp_valid` is high the cycle after E0+1.
- Minimum spacing between accepted requests is WAIT_CYCLES+3 edges, when `resp_ready` is held at 1.
- `req_ready` and `resp_valid` are never both 1.
- `resp_valid` held with `resp_ready`=0: the state stays in RESP indefinitely with stable outputs.
- Store data is visible to a load issued after the store's response handshake.
- Address width: only bits [31:2] index the RAM. Upper bits beyond the index width must be checked for the range error and are not truncated or wrapped.

## Structure
- Shared package `mem_pkg`:
  - `resp_state_t` enum {IDLE, WAIT, RESP};
  - width constants WORD_W=32, WAIT_W=4.
- Sub-module `dmem_array` #(DEPTH): synchronous write port (we, word index, wdata), combinational read port. It holds the RAM; the responder holds the FSM, the `cnt` counter and the request/response registers.

## Test plan
- Reset held low for 2 edges, then released: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Store 7 to 0x64, then load 0x64, with WAIT_CYCLES=2:
  - each `resp_valid` rises 3 edges after acceptance;
  - the load returns `resp_rdata`=7 with `resp_err`=0.
- WAIT_CYCLES=0 back-to-back:
  - store 0x12345678 to 0x0, then load 0x0, `resp_ready` tied 1;
  - the load returns 0x12345678, and requests are accepted every 3 edges.
- Error cases, all returning `resp_err`=1 and `resp_rdata`=0 with RAM unchanged (a reload of 0x64 still returns 7):
  - store to 0x62 (misaligned);
  - store to 0x100 (index 64, out of range);
  - load from 0xFFFF_FF00.
- Backpressure: hold `resp_ready`=0 for 5 cycles in RESP. `resp_valid`, `resp_rdata` and `resp_err` stay stable and `req_ready` stays 0; release and confirm a return to IDLE on the next edge.
- Reset mid-operation: issue a store of 0xDEAD to 0x8 and assert reset during WAIT. After reset, a load of 0x8 returns the prior value, not 0xDEAD.
